// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the shared RAM.
// slave modport is the arbiter's view; master modport is the masters/RAM side.
interface mem_bus_arbiter_if #(
  parameter int AW = 9,
  parameter int DW = 16
);
  logic [2:0]    req0_cmd;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          ack0;
  logic [DW-1:0] rdata0;

  logic [2:0]    req1_cmd;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic          ack1;
  logic [DW-1:0] rdata1;

  logic [2:0]    mem_cmd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;
  logic [1:0]    grant;

  modport slave (
    input  req0_cmd, req0_addr, req0_wdata,
    input  req1_cmd, req1_addr, req1_wdata,
    input  mem_rdata,
    output ack0, rdata0, ack1, rdata1,
    output mem_cmd, mem_addr, mem_wdata,
    output busy, grant
  );

  modport master (
    output req0_cmd, req0_addr, req0_wdata,
    output req1_cmd, req1_addr, req1_wdata,
    output mem_rdata,
    input  ack0, rdata0, ack1, rdata1,
    input  mem_cmd, mem_addr, mem_wdata,
    input  busy, grant
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the shared 512x16 RAM with one-hot mem_cmd encoding.
// Optional MEM_ARB_FIXED_PRIO_EN: master 0 always wins ties instead of round-robin.
module mem_bus_arbiter #(
  parameter int READ_LAT = 1,
  parameter int AW       = 9,
  parameter int DW       = 16
) (
  input  logic         clk,
  input  logic         reset,
  mem_bus_arbiter_if.slave bus
);
  localparam logic [2:0] MNONE  = 3'b001;
  localparam logic [2:0] MREAD  = 3'b010;
  localparam logic [2:0] MWRITE = 3'b100;
  localparam logic [2:0] LAT_LOAD = 3'((READ_LAT < 1) ? 1 : READ_LAT);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state, state_nx;
  logic [2:0]    mem_cmd, mem_cmd_nx;
  logic [AW-1:0] mem_addr, mem_addr_nx;
  logic [DW-1:0] mem_wdata, mem_wdata_nx;
  logic          ack0, ack0_nx, ack1, ack1_nx;
  logic [DW-1:0] rdata0, rdata0_nx, rdata1, rdata1_nx;
  logic          busy, busy_nx;
  logic [1:0]    grant, grant_nx;
  logic          last, last_nx;
  logic [2:0]    lat_cnt, lat_cnt_nx;

  logic valid0, valid1, pick1;

  assign valid0 = (bus.req0_cmd == MREAD) || (bus.req0_cmd == MWRITE);
  assign valid1 = (bus.req1_cmd == MREAD) || (bus.req1_cmd == MWRITE);

  always_comb begin
    state_nx     = state;
    mem_cmd_nx   = mem_cmd;
    mem_addr_nx  = mem_addr;
    mem_wdata_nx = mem_wdata;
    ack0_nx      = ack0;
    ack1_nx      = ack1;
    rdata0_nx    = rdata0;
    rdata1_nx    = rdata1;
    busy_nx      = busy;
    grant_nx     = grant;
    lat_cnt_nx   = lat_cnt;
`ifdef MEM_ARB_FIXED_PRIO_EN
    pick1   = valid1 && !valid0;
    last_nx = last;
`else
    // last names the previous tie winner; the other master takes the next tie
    pick1   = valid1 && (!valid0 || !last);
    last_nx = last;
    if (state == IDLE && valid0 && valid1) last_nx = pick1;
`endif

    case (state)
      IDLE: begin
        mem_cmd_nx = MNONE;
        if (valid0 || valid1) begin
          if (pick1) begin
            grant_nx     = 2'b10;
            mem_cmd_nx   = bus.req1_cmd;
            mem_addr_nx  = bus.req1_addr;
            mem_wdata_nx = bus.req1_wdata;
          end else begin
            grant_nx     = 2'b01;
            mem_cmd_nx   = bus.req0_cmd;
            mem_addr_nx  = bus.req0_addr;
            mem_wdata_nx = bus.req0_wdata;
          end
          busy_nx    = 1'b1;
          lat_cnt_nx = LAT_LOAD;
          state_nx   = ACCESS;
        end
      end
      ACCESS: begin
        if (mem_cmd == MWRITE || lat_cnt <= 3'd1) begin
          if (mem_cmd == MREAD) begin
            if (grant[1]) rdata1_nx = bus.mem_rdata;
            else          rdata0_nx = bus.mem_rdata;
          end
          if (grant[1]) ack1_nx = 1'b1;
          else          ack0_nx = 1'b1;
          mem_cmd_nx = MNONE;
          lat_cnt_nx = '0;
          state_nx   = RESP;
        end else begin
          lat_cnt_nx = lat_cnt - 3'd1;
        end
      end
      RESP: begin
        ack0_nx  = 1'b0;
        ack1_nx  = 1'b0;
        grant_nx = '0;
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
      default: begin
        mem_cmd_nx = MNONE;
        state_nx   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mem_cmd   <= MNONE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      busy      <= 1'b0;
      grant     <= '0;
      last      <= 1'b1;
      lat_cnt   <= '0;
    end else begin
      state     <= state_nx;
      mem_cmd   <= mem_cmd_nx;
      mem_addr  <= mem_addr_nx;
      mem_wdata <= mem_wdata_nx;
      ack0      <= ack0_nx;
      ack1      <= ack1_nx;
      rdata0    <= rdata0_nx;
      rdata1    <= rdata1_nx;
      busy      <= busy_nx;
      grant     <= grant_nx;
      last      <= last_nx;
      lat_cnt   <= lat_cnt_nx;
    end
  end

  assign bus.mem_cmd   = mem_cmd;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.ack0      = ack0;
  assign bus.ack1      = ack1;
  assign bus.rdata0    = rdata0;
  assign bus.rdata1    = rdata1;
  assign bus.busy      = busy;
  assign bus.grant     = grant;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: one instance with READ_LAT=1 and one with
// READ_LAT=3, each with its own RAM model behind the interface.
module tb_mem_bus_arbiter;
  localparam logic [2:0] MNONE  = 3'b001;
  localparam logic [2:0] MREAD  = 3'b010;
  localparam logic [2:0] MWRITE = 3'b100;
`ifdef MEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.AW(9), .DW(16)) ia ();
  mem_bus_arbiter_if #(.AW(9), .DW(16)) ib ();

  mem_bus_arbiter #(.READ_LAT(1), .AW(9), .DW(16)) dut_a (.clk(clk), .reset(reset), .bus(ia));
  mem_bus_arbiter #(.READ_LAT(3), .AW(9), .DW(16)) dut_b (.clk(clk), .reset(reset), .bus(ib));

  logic [15:0] ram_a [512];
  logic [15:0] ram_b [512];

  assign ia.mem_rdata = ram_a[ia.mem_addr];
  assign ib.mem_rdata = ram_b[ib.mem_addr];

  always @(posedge clk) begin
    if (ia.mem_cmd == MWRITE) ram_a[ia.mem_addr] <= ia.mem_wdata;
    if (ib.mem_cmd == MWRITE) ram_b[ib.mem_addr] <= ib.mem_wdata;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int ph, w;
    for (int i = 0; i < 512; i++) begin
      ram_a[i] = '0;
      ram_b[i] = '0;
    end
    ram_a[9'h010] = 16'h1234;
    ram_a[9'h020] = 16'h5678;
    ram_b[9'h1FF] = 16'hC0DE;
    ia.req0_cmd = MNONE; ia.req0_addr = '0; ia.req0_wdata = '0;
    ia.req1_cmd = MNONE; ia.req1_addr = '0; ia.req1_wdata = '0;
    ib.req0_cmd = MNONE; ib.req0_addr = '0; ib.req0_wdata = '0;
    ib.req1_cmd = MNONE; ib.req1_addr = '0; ib.req1_wdata = '0;

    // reset state
    step(); step();
    check("rst_mem_cmd", ia.mem_cmd, MNONE);
    check("rst_mem_addr", ia.mem_addr, 0);
    check("rst_mem_wdata", ia.mem_wdata, 0);
    check("rst_ack", {ia.ack0, ia.ack1}, 0);
    check("rst_rdata", {ia.rdata0, ia.rdata1}, 0);
    check("rst_busy", ia.busy, 0);
    check("rst_grant", ia.grant, 0);
    check("rst_b_mem_cmd", ib.mem_cmd, MNONE);
    reset = 1'b0;

    // master 0 write 005 <= BEEF
    ia.req0_cmd = MWRITE; ia.req0_addr = 9'h005; ia.req0_wdata = 16'hBEEF;
    step();
    check("wr_cmd", ia.mem_cmd, MWRITE);
    check("wr_addr", ia.mem_addr, 9'h005);
    check("wr_wdata", ia.mem_wdata, 16'hBEEF);
    check("wr_grant", ia.grant, 2'b01);
    check("wr_busy", ia.busy, 1);
    check("wr_ack0_early", ia.ack0, 0);
    step();
    check("wr_ack0", ia.ack0, 1);
    check("wr_ack1", ia.ack1, 0);
    check("wr_cmd_done", ia.mem_cmd, MNONE);
    ia.req0_cmd = MNONE;
    step();
    check("wr_ack0_drop", ia.ack0, 0);
    check("wr_grant_idle", ia.grant, 0);
    check("wr_busy_idle", ia.busy, 0);

    // master 1 read 005
    ia.req1_cmd = MREAD; ia.req1_addr = 9'h005;
    step();
    check("rd1_cmd", ia.mem_cmd, MREAD);
    check("rd1_grant", ia.grant, 2'b10);
    check("rd1_ack1_early", ia.ack1, 0);
    step();
    check("rd1_ack1", ia.ack1, 1);
    check("rd1_rdata1", ia.rdata1, 16'hBEEF);
    check("rd1_cmd_done", ia.mem_cmd, MNONE);
    ia.req1_cmd = MNONE;
    step();
    check("rd1_ack1_drop", ia.ack1, 0);
    check("rd1_rdata_hold", ia.rdata1, 16'hBEEF);

    // invalid multi-hot command is ignored
    ia.req0_cmd = 3'b110; ia.req0_addr = 9'h033;
    for (int k = 0; k < 3; k++) begin
      step();
      check("inv_cmd", ia.mem_cmd, MNONE);
      check("inv_busy", ia.busy, 0);
      check("inv_ack", {ia.ack0, ia.ack1}, 0);
    end
    ia.req0_cmd = MNONE;

    // both masters read continuously: ACCESS, RESP, IDLE repeating
    ia.req0_cmd = MREAD; ia.req0_addr = 9'h010;
    ia.req1_cmd = MREAD; ia.req1_addr = 9'h020;
    for (int k = 1; k <= 11; k++) begin
      step();
      ph = (k - 1) % 3;
      w = FIXED ? 0 : ((k - 1) / 3) % 2;
      check("cont_grant", ia.grant, (ph == 2) ? 2'b00 : (w == 1 ? 2'b10 : 2'b01));
      check("cont_ack0", ia.ack0, (ph == 1 && w == 0) ? 1 : 0);
      check("cont_ack1", ia.ack1, (ph == 1 && w == 1) ? 1 : 0);
      check("cont_busy", ia.busy, (ph == 2) ? 0 : 1);
      if (ph == 0) begin
        check("cont_cmd", ia.mem_cmd, MREAD);
        check("cont_addr", ia.mem_addr, (w == 1) ? 9'h020 : 9'h010);
      end
      if (ph == 1) begin
        if (w == 1) check("cont_rdata1", ia.rdata1, 16'h5678);
        else        check("cont_rdata0", ia.rdata0, 16'h1234);
      end
    end
    ia.req0_cmd = MNONE; ia.req1_cmd = MNONE;
    step();
    check("cont_end_grant", ia.grant, 0);
    check("cont_end_busy", ia.busy, 0);

    // READ_LAT=3: master 0 reads 1FF
    ib.req0_cmd = MREAD; ib.req0_addr = 9'h1FF;
    for (int k = 1; k <= 3; k++) begin
      step();
      check("lat3_cmd", ib.mem_cmd, MREAD);
      check("lat3_addr", ib.mem_addr, 9'h1FF);
      check("lat3_grant", ib.grant, 2'b01);
      check("lat3_ack0_early", ib.ack0, 0);
    end
    step();
    check("lat3_ack0", ib.ack0, 1);
    check("lat3_rdata0", ib.rdata0, 16'hC0DE);
    check("lat3_grant_resp", ib.grant, 2'b01);
    check("lat3_cmd_done", ib.mem_cmd, MNONE);
    ib.req0_cmd = MNONE;
    step();
    check("lat3_idle_grant", ib.grant, 0);
    check("lat3_idle_ack0", ib.ack0, 0);

    // tie, then master 1 alone, then reset during its ACCESS
    ib.req0_cmd = MREAD; ib.req0_addr = 9'h1FF;
    ib.req1_cmd = MREAD; ib.req1_addr = 9'h00A;
    step();
    check("abt_tie_grant", ib.grant, 2'b01);
    step(); step(); step();
    check("abt_ack0", ib.ack0, 1);
    ib.req0_cmd = MNONE;
    step();
    check("abt_idle_grant", ib.grant, 0);
    step();
    check("abt_m1_grant", ib.grant, 2'b10);
    check("abt_m1_cmd", ib.mem_cmd, MREAD);
    check("abt_m1_addr", ib.mem_addr, 9'h00A);
    reset = 1'b1;
    step();
    check("abt_cmd", ib.mem_cmd, MNONE);
    check("abt_ack", {ib.ack0, ib.ack1}, 0);
    check("abt_grant", ib.grant, 0);
    check("abt_busy", ib.busy, 0);
    check("abt_rdata0", ib.rdata0, 0);
    reset = 1'b0;
    ib.req0_cmd = MREAD; ib.req0_addr = 9'h1FF;
    step();
    check("post_rst_grant", ib.grant, 2'b01);
    check("post_rst_addr", ib.mem_addr, 9'h1FF);
    step(); step();
    check("post_rst_ack_early", {ib.ack0, ib.ack1}, 0);
    step();
    check("post_rst_ack0", ib.ack0, 1);
    check("post_rst_ack1", ib.ack1, 0);
    check("post_rst_rdata0", ib.rdata0, 16'hC0DE);
    ib.req0_cmd = MNONE; ib.req1_cmd = MNONE;
    step();
    check("post_rst_idle", ib.grant, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
